pls_decode: RTL and testbench

Step/direction pulse decoder: the receiving end of the `pls_cont` output. It synchronizes external `pls`/`dir` lines, maintains a signed position counter, and compresses runs of equal-direction steps into segment records `(N, T)` matching the `pls_cont` input format. Records are written into a downstream FIFO. It is used for loop-back verification of the pulse generator and for capturing manual-pulse-generator input.

---
 rtl/pls_pkg.sv | 25 ++
 rtl/sync_edge.sv | 51 +++++
 rtl/pls_decode.sv | 186 ++++++++++++++++++
 tb/tb_pls_decode.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pls_pkg.sv
// Shared types for the step/direction pulse decoder: segment record, FSM states and
// counter limits.
package pls_pkg;

  typedef struct packed {
    logic signed [31:0] N;
    logic        [31:0] T;
  } seg_t;

  localparam logic [31:0] T_UNKNOWN = 32'hFFFF_FFFF;

  // Largest step count a single segment may hold, in either direction.
  localparam logic signed [31:0] CNT_POS_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] CNT_NEG_MAX = 32'sh8000_0001;

  typedef enum logic {
    IDLE,
    ACCUM
  } dec_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage input synchronizer with an optional rising-edge detector on the
// synchronized output.
module sync_edge #(
  parameter int unsigned STAGES = 2,
  parameter bit          EDGE   = 1'b1
) (
  input  logic clk,
  input  logic aclr_n,
  input  logic sclr,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = sclr ? '0 : {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

  if (EDGE) begin : g_edge
    logic prev_q, prev_d;

    always_comb begin
      prev_d = sclr ? 1'b0 : q;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= prev_d;
      end
    end

    assign rise = q & ~prev_q;
  end else begin : g_no_edge
    assign rise = 1'b0;
  end

endmodule

// File: rtl/pls_decode.sv
// Step/direction pulse decoder: tracks absolute position and compresses runs of
// same-direction steps into (N, T) segment records written to a downstream FIFO.
module pls_decode
  import pls_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1_000_000
) (
  input  logic               clk,
  input  logic               aclr_n,
  input  logic               sclr,
  input  logic               enable,
  input  logic               pls,
  input  logic               dir,
  output logic signed [31:0] seg_N,
  output logic        [31:0] seg_T,
  output logic               seg_wrreq,
  input  logic               seg_full,
  output logic signed [31:0] pos,
  output logic               busy,
  output logic               ovf
);

  localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);

  logic pls_rise, pls_s_unused;
  logic dir_s, dir_rise_unused;

  sync_edge #(
    .STAGES(SYNC_STAGES),
    .EDGE  (1'b1)
  ) u_pls_sync (
    .clk   (clk),
    .aclr_n(aclr_n),
    .sclr  (sclr),
    .d     (pls),
    .q     (pls_s_unused),
    .rise  (pls_rise)
  );

  sync_edge #(
    .STAGES(SYNC_STAGES),
    .EDGE  (1'b0)
  ) u_dir_sync (
    .clk   (clk),
    .aclr_n(aclr_n),
    .sclr  (sclr),
    .d     (dir),
    .q     (dir_s),
    .rise  (dir_rise_unused)
  );

  dec_state_t         state_q, state_d;
  logic signed [31:0] cnt_q, cnt_d;
  logic               sdir_q, sdir_d;
  logic        [31:0] tlast_q, tlast_d;
  logic        [31:0] pcnt_q, pcnt_d;
  logic               pending_q, pending_d;
  seg_t               seg_q, seg_d;
  logic signed [31:0] pos_q, pos_d;
  logic               ovf_q, ovf_d;

  logic               step;
  logic signed [31:0] delta;
  logic signed [31:0] cnt_inc;
  logic        [31:0] period;
  logic               emit;
  seg_t               rec;

  assign seg_wrreq = pending_q & ~seg_full;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sdir_d    = sdir_q;
    tlast_d   = tlast_q;
    pending_d = pending_q;
    seg_d     = seg_q;
    pos_d     = pos_q;
    ovf_d     = ovf_q;
    emit      = 1'b0;
    rec       = '{N: cnt_q, T: tlast_q};

    step    = pls_rise & enable;
    delta   = dir_s ? 32'sd1 : -32'sd1;
    cnt_inc = cnt_q + delta;
    // Cycles since the previous step: the counter was cleared in that step's cycle.
    period  = sat_inc(pcnt_q);

    pcnt_d = step ? 32'd0 : sat_inc(pcnt_q);
    if (step) begin
      pos_d = pos_q + delta;
    end

    if (seg_wrreq) begin
      pending_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (step) begin
          state_d = ACCUM;
          cnt_d   = delta;
          sdir_d  = dir_s;
          tlast_d = T_UNKNOWN;
        end
      end
      ACCUM: begin
        if (!enable) begin
          emit    = 1'b1;
          state_d = IDLE;
        end else if (step && (dir_s == sdir_q)) begin
          cnt_d   = cnt_inc;
          tlast_d = period;
          if ((cnt_inc == CNT_POS_MAX) || (cnt_inc == CNT_NEG_MAX)) begin
            emit    = 1'b1;
            rec     = '{N: cnt_inc, T: period};
            state_d = IDLE;
          end
        end else if (step) begin
          emit    = 1'b1;
          cnt_d   = delta;
          sdir_d  = dir_s;
          tlast_d = T_UNKNOWN;
        end else if (pcnt_q == TmoLast) begin
          emit    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A record still waiting for the FIFO wins; the newer one is lost.
    if (emit) begin
      if (pending_q) begin
        ovf_d = 1'b1;
      end else begin
        seg_d     = rec;
        pending_d = 1'b1;
      end
    end

    if (sclr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      sdir_d    = 1'b0;
      tlast_d   = '0;
      pcnt_d    = '0;
      pending_d = 1'b0;
      seg_d     = '0;
      pos_d     = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sdir_q    <= 1'b0;
      tlast_q   <= '0;
      pcnt_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= '0;
      pos_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sdir_q    <= sdir_d;
      tlast_q   <= tlast_d;
      pcnt_q    <= pcnt_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      pos_q     <= pos_d;
      ovf_q     <= ovf_d;
    end
  end

  assign seg_N = seg_q.N;
  assign seg_T = seg_q.T;
  assign pos   = pos_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == ACCUM) | pending_q;

endmodule

// File: tb/tb_pls_decode.sv
// Self-checking bench for pls_decode: expected segment records are queued as pulses
// are driven and compared as the decoder writes them out.
module tb_pls_decode;
  import pls_pkg::*;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 1000;

  logic               clk = 1'b0;
  logic               aclr_n, sclr, enable, pls, dir, seg_full;
  logic signed [31:0] seg_N, pos;
  logic        [31:0] seg_T;
  logic               seg_wrreq, busy, ovf;

  int                 n_checks = 0;
  int                 n_fail = 0;
  int                 wr_count = 0;
  int                 cyc = 0;
  int                 last_wr_cyc = 0;
  int                 last_rise_cyc = 0;
  logic signed [31:0] exp_pos = 0;
  seg_t               exp_q[$];

  pls_decode #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .sclr     (sclr),
    .enable   (enable),
    .pls      (pls),
    .dir      (dir),
    .seg_N    (seg_N),
    .seg_T    (seg_T),
    .seg_wrreq(seg_wrreq),
    .seg_full (seg_full),
    .pos      (pos),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every FIFO write must match the oldest expected record.
  always @(negedge clk) begin
    if (aclr_n && seg_wrreq) begin
      seg_t e;
      wr_count    = wr_count + 1;
      last_wr_cyc = cyc;
      n_checks    = n_checks + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_write: got N=%0d T=%h, required no write", seg_N, seg_T);
      end else begin
        e = exp_q.pop_front();
        if (seg_N !== e.N || seg_T !== e.T) begin
          n_fail = n_fail + 1;
          $display("FAIL write_record: got N=%0d T=%h, required N=%0d T=%h",
                   seg_N, seg_T, e.N, e.T);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One step pulse (3 cycles high), rises spaced exactly `spacing` cycles apart.
  task automatic pulse(input logic d, input int spacing);
    dir = d;
    tick();
    pls           = 1'b1;
    last_rise_cyc = cyc;
    repeat (3) tick();
    pls = 1'b0;
    repeat (spacing - 4) tick();
  endtask

  task automatic test_reset();
    n_checks += 6;
    if (seg_N !== 32'sd0) begin n_fail++; $display("FAIL reset_seg_N: got %0d required 0", seg_N); end
    if (seg_T !== 32'd0) begin n_fail++; $display("FAIL reset_seg_T: got %0d required 0", seg_T); end
    if (seg_wrreq !== 1'b0) begin n_fail++; $display("FAIL reset_wrreq: got %b required 0", seg_wrreq); end
    if (pos !== 32'sd0) begin n_fail++; $display("FAIL reset_pos: got %0d required 0", pos); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", ovf); end
  endtask

  task automatic test_single_dir();
    int w0 = wr_count;
    exp_q.push_back('{N: 32'sd5, T: 32'd300});
    repeat (5) pulse(1'b1, 300);
    exp_pos += 5;
    for (int i = 0; i < int'(TIMEOUT) + 50 && wr_count < w0 + 1; i++) tick();
    tick();
    n_checks += 4;
    if (wr_count !== w0 + 1) begin n_fail++; $display("FAIL single_dir_writes: got %0d required 1", wr_count - w0); end
    if (last_wr_cyc - last_rise_cyc !== int'(TIMEOUT + SYNC_STAGES + 1)) begin
      n_fail++;
      $display("FAIL single_dir_latency: got %0d required %0d", last_wr_cyc - last_rise_cyc,
               TIMEOUT + SYNC_STAGES + 1);
    end
    if (pos !== exp_pos) begin n_fail++; $display("FAIL single_dir_pos: got %0d required %0d", pos, exp_pos); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_dir_busy: got %b required 0", busy); end
  endtask

  task automatic test_dir_change();
    int w0 = wr_count;
    exp_q.push_back('{N: -32'sd2, T: 32'd300});
    exp_q.push_back('{N: 32'sd3, T: 32'd200});
    repeat (2) pulse(1'b0, 300);
    repeat (3) pulse(1'b1, 200);
    exp_pos += 1;
    for (int i = 0; i < int'(TIMEOUT) + 50 && wr_count < w0 + 2; i++) tick();
    n_checks += 2;
    if (wr_count !== w0 + 2) begin n_fail++; $display("FAIL dir_change_writes: got %0d required 2", wr_count - w0); end
    if (pos !== exp_pos) begin n_fail++; $display("FAIL dir_change_pos: got %0d required %0d", pos, exp_pos); end
  endtask

  task automatic test_single_pulse();
    int w0 = wr_count;
    exp_q.push_back('{N: 32'sd1, T: T_UNKNOWN});
    pulse(1'b1, 50);
    exp_pos += 1;
    for (int i = 0; i < int'(TIMEOUT) + 50 && wr_count < w0 + 1; i++) tick();
    n_checks += 2;
    if (wr_count !== w0 + 1) begin n_fail++; $display("FAIL single_pulse_writes: got %0d required 1", wr_count - w0); end
    if (pos !== exp_pos) begin n_fail++; $display("FAIL single_pulse_pos: got %0d required %0d", pos, exp_pos); end
  endtask

  task automatic test_full();
    int w0 = wr_count;
    seg_full = 1'b1;
    exp_q.push_back('{N: 32'sd2, T: 32'd300});
    pulse(1'b1, 300);
    pulse(1'b1, 300);
    pulse(1'b0, 300);
    pulse(1'b1, 300);
    exp_pos += 2;
    // Let the trailing one-step segment time out too; it must also be dropped.
    repeat (TIMEOUT + 20) tick();
    n_checks += 6;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL full_ovf: got %b required 1", ovf); end
    if (seg_wrreq !== 1'b0) begin n_fail++; $display("FAIL full_wrreq: got %b required 0", seg_wrreq); end
    if (seg_N !== 32'sd2) begin n_fail++; $display("FAIL full_held_N: got %0d required 2", seg_N); end
    if (seg_T !== 32'd300) begin n_fail++; $display("FAIL full_held_T: got %0d required 300", seg_T); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b required 1", busy); end
    if (wr_count !== w0) begin n_fail++; $display("FAIL full_no_write: got %0d required 0", wr_count - w0); end
    seg_full = 1'b0;
    repeat (20) tick();
    n_checks += 3;
    if (wr_count !== w0 + 1) begin n_fail++; $display("FAIL full_release_writes: got %0d required 1", wr_count - w0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL full_release_busy: got %b required 0", busy); end
    if (pos !== exp_pos) begin n_fail++; $display("FAIL full_pos: got %0d required %0d", pos, exp_pos); end
  endtask

  task automatic test_enable();
    int w0 = wr_count;
    exp_q.push_back('{N: 32'sd4, T: 32'd250});
    repeat (4) pulse(1'b1, 250);
    exp_pos += 4;
    enable = 1'b0;
    for (int i = 0; i < 5 && wr_count < w0 + 1; i++) tick();
    n_checks += 1;
    if (wr_count !== w0 + 1) begin n_fail++; $display("FAIL enable_drop_write: got %0d required 1", wr_count - w0); end
    repeat (3) pulse(1'b1, 100);
    n_checks += 3;
    if (pos !== exp_pos) begin n_fail++; $display("FAIL enable_off_pos: got %0d required %0d", pos, exp_pos); end
    if (wr_count !== w0 + 1) begin n_fail++; $display("FAIL enable_off_writes: got %0d required 1", wr_count - w0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL enable_off_busy: got %b required 0", busy); end
    enable = 1'b1;
    tick();
  endtask

  // Clear mid-segment either via sclr (use_aclr=0) or aclr_n (use_aclr=1).
  task automatic test_clear(input bit use_aclr);
    int w0 = wr_count;
    logic d = use_aclr ? 1'b0 : 1'b1;
    repeat (2) pulse(d, 300);
    if (use_aclr) begin
      aclr_n = 1'b0;
      #2;
    end else begin
      sclr = 1'b1;
      tick();
    end
    n_checks += 6;
    if (seg_N !== 32'sd0) begin n_fail++; $display("FAIL clear%0d_seg_N: got %0d required 0", use_aclr, seg_N); end
    if (seg_T !== 32'd0) begin n_fail++; $display("FAIL clear%0d_seg_T: got %0d required 0", use_aclr, seg_T); end
    if (seg_wrreq !== 1'b0) begin n_fail++; $display("FAIL clear%0d_wrreq: got %b required 0", use_aclr, seg_wrreq); end
    if (pos !== 32'sd0) begin n_fail++; $display("FAIL clear%0d_pos: got %0d required 0", use_aclr, pos); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clear%0d_busy: got %b required 0", use_aclr, busy); end
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL clear%0d_ovf: got %b required 0", use_aclr, ovf); end
    tick();
    aclr_n  = 1'b1;
    sclr    = 1'b0;
    exp_pos = 0;
    repeat (TIMEOUT + 20) tick();
    n_checks += 1;
    if (wr_count !== w0) begin n_fail++; $display("FAIL clear%0d_no_write: got %0d required 0", use_aclr, wr_count - w0); end
    exp_q.push_back('{N: (d ? 32'sd1 : -32'sd1), T: T_UNKNOWN});
    pulse(d, 50);
    exp_pos = d ? 32'sd1 : -32'sd1;
    for (int i = 0; i < int'(TIMEOUT) + 50 && wr_count < w0 + 1; i++) tick();
    n_checks += 2;
    if (wr_count !== w0 + 1) begin n_fail++; $display("FAIL clear%0d_fresh_writes: got %0d required 1", use_aclr, wr_count - w0); end
    if (pos !== exp_pos) begin n_fail++; $display("FAIL clear%0d_fresh_pos: got %0d required %0d", use_aclr, pos, exp_pos); end
  endtask

  initial begin
    aclr_n   = 1'b0;
    sclr     = 1'b0;
    enable   = 1'b1;
    pls      = 1'b0;
    dir      = 1'b0;
    seg_full = 1'b0;
    repeat (3) tick();
    aclr_n = 1'b1;
    tick();
    test_reset();
    test_single_dir();
    test_dir_change();
    test_single_pulse();
    test_full();
    test_enable();
    test_clear(1'b0);
    test_clear(1'b1);
    repeat (5) tick();
    n_checks += 1;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL leftover_records: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
